// File: rtl/uart_cmd_decoder_pkg.sv
// Shared definitions for the host UART command decoder:
// sync byte, error codes, FSM states and uart_ctrl bit positions.
package uart_cmd_decoder_pkg;

    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

    localparam int RX_VALID_BIT  = 0;
    localparam int FRAME_ERR_BIT = 1;

    typedef enum logic [1:0] {
        ERR_CHECKSUM = 2'd0,
        ERR_TIMEOUT  = 2'd1,
        ERR_FRAMING  = 2'd2,
        ERR_OVERRUN  = 2'd3
    } err_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HOST = 3'd1,
        S_CMD  = 3'd2,
        S_ARG  = 3'd3,
        S_CHK  = 3'd4,
        S_HOLD = 3'd5
    } state_t;

    // True while a packet is partially received (inter-byte timeout armed)
    function automatic logic in_packet(input state_t s);
        return (s == S_HOST) || (s == S_CMD) || (s == S_ARG) || (s == S_CHK);
    endfunction

endpackage

// File: rtl/uart_cmd_decoder_timeout.sv
// Inter-byte timeout: clearable counter that pulses expired when it
// reaches TIMEOUT_CYCLES-1 while enabled and not being cleared.
module uart_rx_timeout #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic ex_clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT_CYCLES);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt;

    assign expired = en & ~clr & (cnt == LAST);

    // Count idle cycles while armed; a byte or disarm restarts from zero
    always_ff @(posedge ex_clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr | ~en | expired) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_cmd_decoder.sv
// Frames host UART bytes into 8-byte command packets, validates them
// and presents the decoded command to sd_fsm with a valid/ready handshake.
module uart_cmd_decoder
    import uart_cmd_decoder_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = DEF_SYNC_BYTE,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic        ex_clk,
    input  logic        reset,
    input  logic [7:0]  uart_rx_data,
    input  logic [7:0]  uart_ctrl,
    input  logic        cmd_ready,
    output logic        uart_cmd_en,
    output logic [3:0]  host_cmd,
    output logic [5:0]  uart_cmd,
    output logic [31:0] cmd_arg,
    output logic        parse_err,
    output logic [1:0]  err_code
);

    state_t      state, state_n;
    err_t        err_val;
    logic        rx_valid, rx_ferr, is_sync;
    logic        tmo_expired, load_out, err_set;
    logic [3:0]  stg_host;
    logic [5:0]  stg_cmd;
    logic [31:0] stg_arg;
    logic [7:0]  xsum;
    logic [1:0]  arg_idx;
    logic        unused_ctrl;

    assign rx_valid    = uart_ctrl[RX_VALID_BIT];
    assign rx_ferr     = uart_ctrl[FRAME_ERR_BIT];
    assign is_sync     = rx_valid & ~rx_ferr & (uart_rx_data == SYNC_BYTE);
    assign unused_ctrl = ^uart_ctrl[7:2];

    uart_rx_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .ex_clk (ex_clk),
        .reset  (reset),
        .clr    (rx_valid),
        .en     (in_packet(state)),
        .expired(tmo_expired)
    );

    // State register
    always_ff @(posedge ex_clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    // Next state, output load and error decisions
    always_comb begin
        state_n  = state;
        load_out = 1'b0;
        err_set  = 1'b0;
        err_val  = ERR_CHECKSUM;
        unique case (state)
            S_IDLE: begin
                if (is_sync) state_n = S_HOST;
            end
            S_HOST, S_CMD, S_ARG, S_CHK: begin
                if (rx_valid && rx_ferr) begin
                    state_n = S_IDLE;
                    err_set = 1'b1;
                    err_val = ERR_FRAMING;
                end else if (rx_valid) begin
                    if (state == S_HOST) begin
                        state_n = S_CMD;
                    end else if (state == S_CMD) begin
                        state_n = S_ARG;
                    end else if (state == S_ARG) begin
                        state_n = (arg_idx == 2'd3) ? S_CHK : S_ARG;
                    end else if (uart_rx_data == xsum) begin
                        state_n  = S_HOLD;
                        load_out = 1'b1;
                    end else begin
                        state_n = S_IDLE;
                        err_set = 1'b1;
                        err_val = ERR_CHECKSUM;
                    end
                end else if (tmo_expired) begin
                    state_n = S_IDLE;
                    err_set = 1'b1;
                    err_val = ERR_TIMEOUT;
                end
            end
            S_HOLD: begin
                if (cmd_ready) begin
                    state_n = is_sync ? S_HOST : S_IDLE;
                end else if (rx_valid) begin
                    err_set = 1'b1;
                    err_val = ERR_OVERRUN;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Staging capture and running checksum
    always_ff @(posedge ex_clk) begin
        if (reset) begin
            stg_host <= '0;
            stg_cmd  <= '0;
            stg_arg  <= '0;
            xsum     <= '0;
            arg_idx  <= '0;
        end else if (rx_valid) begin
            if (state == S_HOST) begin
                stg_host <= uart_rx_data[3:0];
                xsum     <= uart_rx_data;
                arg_idx  <= '0;
            end
            if (state == S_CMD) begin
                stg_cmd <= uart_rx_data[5:0];
                xsum    <= xsum ^ uart_rx_data;
            end
            if (state == S_ARG) begin
                stg_arg <= {stg_arg[23:0], uart_rx_data};
                xsum    <= xsum ^ uart_rx_data;
                arg_idx <= arg_idx + 2'd1;
            end
        end
    end

    // Presented command, handshake and error reporting
    always_ff @(posedge ex_clk) begin
        if (reset) begin
            uart_cmd_en <= 1'b0;
            host_cmd    <= '0;
            uart_cmd    <= '0;
            cmd_arg     <= '0;
            parse_err   <= 1'b0;
            err_code    <= '0;
        end else begin
            parse_err <= err_set;
            if (err_set) err_code <= err_val;
            if (load_out) begin
                uart_cmd_en <= 1'b1;
                host_cmd    <= stg_host;
                uart_cmd    <= stg_cmd;
                cmd_arg     <= stg_arg;
            end else if (state == S_HOLD && cmd_ready) begin
                uart_cmd_en <= 1'b0;
            end
        end
    end

endmodule
